// File: rtl/mac_dot_sequencer_if.sv
// Signal bundle between the dot-product sequencer, its operand source,
// its result consumer and the external MAC accumulator.
interface mac_dot_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
);
  logic                      start;
  logic [LEN_W-1:0]          len;
  logic                      abort;
  logic                      busy;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   in_w;
  logic signed [WIDTH-1:0]   in_x;
  logic                      mac_clr;
  logic                      mac_en;
  logic signed [WIDTH-1:0]   mac_w;
  logic signed [WIDTH-1:0]   mac_x;
  logic signed [2*WIDTH-1:0] mac_out;
  logic                      res_valid;
  logic                      res_ready;
  logic signed [2*WIDTH-1:0] res_data;

  // Sequencer side
  modport slave (
    input  start, len, abort, in_valid, in_w, in_x, mac_out, res_ready,
    output busy, in_ready, mac_clr, mac_en, mac_w, mac_x, res_valid, res_data
  );

  // Environment side (operand source, result consumer, MAC)
  modport master (
    output start, len, abort, in_valid, in_w, in_x, mac_out, res_ready,
    input  busy, in_ready, mac_clr, mac_en, mac_w, mac_x, res_valid, res_data
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Sequences one external MAC accumulator through a signed dot product of
// 'len' operand pairs: clear, accumulate on each accepted pair, capture the
// MAC output and hold it on the result port until the consumer takes it.
module mac_dot_sequencer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input logic                clk,
  input logic                rst,
  mac_dot_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [LEN_W-1:0]          cnt_r;
  logic [LEN_W-1:0]          cnt_nxt_s;
  logic signed [2*WIDTH-1:0] res_data_r;
  logic signed [2*WIDTH-1:0] res_data_nxt_s;

  // State, remaining-pair count and captured result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {LEN_W{1'b0}};
      res_data_r <= {(2*WIDTH){1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      res_data_r <= res_data_nxt_s;
    end
  end

  // Next state, count update and result capture; abort beats any handshake
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    res_data_nxt_s = res_data_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_nxt_s   = bus.len;
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (bus.abort) begin
          cnt_nxt_s   = {LEN_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else if (cnt_r != {LEN_W{1'b0}}) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          // Zero-length run: the freshly cleared MAC already holds the answer
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_ACCUM: begin
        if (bus.abort) begin
          cnt_nxt_s   = {LEN_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else if (bus.in_valid) begin
          cnt_nxt_s = cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          cnt_nxt_s   = {LEN_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else begin
          // The last enabled MAC edge has passed, so mac_out is final here
          res_data_nxt_s = bus.mac_out;
          state_nxt_s    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.abort) begin
          cnt_nxt_s   = {LEN_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else if (bus.res_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        cnt_nxt_s   = {LEN_W{1'b0}};
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the state register plus MAC operand pass-through
  always_comb begin
    bus.busy      = (state_r != ST_IDLE);
    bus.in_ready  = (state_r == ST_ACCUM);
    bus.res_valid = (state_r == ST_HOLD);
    bus.res_data  = res_data_r;
    bus.mac_en    = (state_r == ST_ACCUM) & bus.in_valid;
    bus.mac_w     = bus.in_w;
    bus.mac_x     = bus.in_x;
    bus.mac_clr   = rst | (state_r == ST_CLEAR) | (bus.abort & (state_r != ST_IDLE));
  end

endmodule
